// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the two-road traffic light bus: decodes lA/lB into
// the 8-phase sequence and flags illegal codes, conflicts, misordering and dwell faults.
module traffic_light_monitor #(
  parameter int unsigned TRANS_CYCLES = 1,
  parameter int unsigned DWELL_W      = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         lA,
  input  logic [1:0]         lB,
  input  logic               clr_err,
  output logic               locked,
  output logic [2:0]         phase,
  output logic [DWELL_W-1:0] green_dwell,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               err_pulse,
  output logic [1:0]         err_code,
  output logic               err_sticky
);

  localparam logic [1:0] C_G = 2'b00;
  localparam logic [1:0] C_Y = 2'b01;
  localparam logic [1:0] C_R = 2'b10;
  localparam logic [1:0] C_X = 2'b11;
  localparam logic [DWELL_W-1:0] TC = DWELL_W'(TRANS_CYCLES);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  // Expected {lA,lB} for each phase of the sequence
  function automatic logic [3:0] phase_pair(input logic [2:0] p);
    case (p)
      3'd0:    phase_pair = {C_G, C_R};
      3'd1:    phase_pair = {C_Y, C_R};
      3'd2:    phase_pair = {C_R, C_R};
      3'd3:    phase_pair = {C_R, C_Y};
      3'd4:    phase_pair = {C_R, C_G};
      3'd5:    phase_pair = {C_R, C_Y};
      3'd6:    phase_pair = {C_R, C_R};
      default: phase_pair = {C_Y, C_R};
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         phase_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               over_q, over_d;
  logic               locked_d;
  logic [DWELL_W-1:0] green_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               err;
  logic [1:0]         code_d;
  logic               sticky_d;
  logic [3:0]         pair, cur_pair, nxt_pair;
  logic               inv, conflict, trans;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      phase       <= 3'd0;
      dwell_q     <= '0;
      over_q      <= 1'b0;
      locked      <= 1'b0;
      green_dwell <= '0;
      cycle_count <= '0;
      err_pulse   <= 1'b0;
      err_code    <= 2'd0;
      err_sticky  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase       <= phase_d;
      dwell_q     <= dwell_d;
      over_q      <= over_d;
      locked      <= locked_d;
      green_dwell <= green_d;
      cycle_count <= cnt_d;
      err_pulse   <= err;
      err_code    <= code_d;
      err_sticky  <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase;
    dwell_d  = dwell_q;
    over_d   = over_q;
    cnt_d    = cycle_count;
    err      = 1'b0;
    code_d   = err_code;
    pair     = {lA, lB};
    cur_pair = phase_pair(phase);
    nxt_pair = phase_pair(phase + 3'd1);
    inv      = (lA == C_X) || (lB == C_X);
    conflict = (lA != C_R) && (lB != C_R);
    trans    = (phase != 3'd0) && (phase != 3'd4);

    if (inv) begin
      err    = 1'b1;
      code_d = 2'd0;
    end else if (conflict) begin
      err    = 1'b1;
      code_d = 2'd1;
    end else if (state_q == LOCKED && pair != cur_pair && pair != nxt_pair) begin
      err    = 1'b1;
      code_d = 2'd2;
    end

    // Fatal errors and the unlocked state share the same (re)lock search
    if (err || state_q == UNLOCKED) begin
      state_d = UNLOCKED;
      phase_d = 3'd0;
      dwell_d = '0;
      over_d  = 1'b0;
      if (pair == {C_G, C_R}) begin
        state_d = LOCKED;
        dwell_d = DWELL_W'(1);
      end else if (pair == {C_R, C_G}) begin
        state_d = LOCKED;
        phase_d = 3'd4;
        dwell_d = DWELL_W'(1);
      end
    end else if (pair == cur_pair) begin
      if (trans) begin
        if (dwell_q >= TC) begin
          if (!over_q) begin
            err    = 1'b1;
            code_d = 2'd3;
            over_d = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end else if (dwell_q != '1) begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end else begin
      if (trans && dwell_q < TC) begin
        err    = 1'b1;
        code_d = 2'd3;
      end
      phase_d = phase + 3'd1;
      dwell_d = DWELL_W'(1);
      over_d  = 1'b0;
      if (phase == 3'd7) cnt_d = cycle_count + CNT_W'(1);
    end

    locked_d = (state_d == LOCKED);
    green_d  = (locked_d && (phase_d == 3'd0 || phase_d == 3'd4)) ? dwell_d : '0;
    sticky_d = err ? 1'b1 : (clr_err ? 1'b0 : err_sticky);
  end

endmodule
